// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with a built-in load-use interlock and a
// saturating stall-cycle counter.
//
// Flow control: stall acts as the inverse of "ready" toward the front end.
// An ID instruction (id_valid=1) is accepted at a rising edge only when
// stall=0 and flush=0. While stall=1 the front end must hold PC and IF/ID and
// keep presenting the same instruction. EX receives a bubble (ex_valid=0) on
// any edge where nothing is accepted.
module id_ex_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_RegDst,
    input  logic              id_RegWrite,
    input  logic              id_MemRead,
    input  logic              id_MemWrite,
    input  logic              id_MemtoReg,
    input  logic              id_Branch,
    input  logic              id_ALUSrc,
    input  logic [1:0]        id_ALUOp,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_RegDst,
    output logic              ex_RegWrite,
    output logic              ex_MemRead,
    output logic              ex_MemWrite,
    output logic              ex_MemtoReg,
    output logic              ex_Branch,
    output logic              ex_ALUSrc,
    output logic [1:0]        ex_ALUOp,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic usesRt;
    logic hazard;
    logic loadBubble;

    // Load-use detection: a load in EX whose nonzero destination is read by the ID instruction.
    always_comb begin
        usesRt     = ~id_ALUSrc | id_MemWrite | id_Branch;
        hazard     = id_valid & ex_valid & ex_MemRead & (ex_rt != '0) &
                     ((ex_rt == id_rs) | (usesRt & (ex_rt == id_rt)));
        // A squashed instruction must never hold the front end.
        stall      = hazard & ~flush;
        loadBubble = flush | stall | ~id_valid;
    end

    // Valid bit and control word: cleared to a clean bubble whenever nothing is accepted.
    always_ff @(posedge clk) begin
        if (rst || loadBubble) begin
            ex_valid    <= 1'b0;
            ex_RegDst   <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_MemWrite <= 1'b0;
            ex_MemtoReg <= 1'b0;
            ex_Branch   <= 1'b0;
            ex_ALUSrc   <= 1'b0;
            ex_ALUOp    <= 2'b00;
        end else begin
            ex_valid    <= 1'b1;
            ex_RegDst   <= id_RegDst;
            ex_RegWrite <= id_RegWrite;
            ex_MemRead  <= id_MemRead;
            ex_MemWrite <= id_MemWrite;
            ex_MemtoReg <= id_MemtoReg;
            ex_Branch   <= id_Branch;
            ex_ALUSrc   <= id_ALUSrc;
            ex_ALUOp    <= id_ALUOp;
        end
    end

    // Data and specifier fields: loaded every edge; meaningless while ex_valid=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_pc4     <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd      <= '0;
        end else begin
            ex_pc4     <= id_pc4;
            ex_rs_data <= id_rs_data;
            ex_rt_data <= id_rt_data;
            ex_imm     <= id_imm;
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_rd      <= id_rd;
        end
    end

    // Stall-cycle counter: counts edges with stall=1, sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed instruction pairs, a behavioural model of
// "what sits in EX", a per-cycle compare process and literal spot checks.
module tb_id_ex_pipe_reg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc4;
        logic [DATA_W-1:0] rsData;
        logic [DATA_W-1:0] rtData;
        logic [DATA_W-1:0] imm;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic              regDst;
        logic              regWrite;
        logic              memRead;
        logic              memWrite;
        logic              memtoReg;
        logic              branch;
        logic              aluSrc;
        logic [1:0]        aluOp;
    } ins_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    ins_t cur = '0;
    initial forever #5 clk = ~clk;

    // ---------------- DUT (default counter width) ----------------
    logic              ex_valid, ex_RegDst, ex_RegWrite, ex_MemRead, ex_MemWrite;
    logic              ex_MemtoReg, ex_Branch, ex_ALUSrc, stall;
    logic [1:0]        ex_ALUOp;
    logic [DATA_W-1:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
    logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
    logic [15:0]       stall_cnt;

    id_ex_pipe_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(cur.valid),
        .id_pc4(cur.pc4), .id_rs_data(cur.rsData), .id_rt_data(cur.rtData), .id_imm(cur.imm),
        .id_rs(cur.rs), .id_rt(cur.rt), .id_rd(cur.rd),
        .id_RegDst(cur.regDst), .id_RegWrite(cur.regWrite), .id_MemRead(cur.memRead),
        .id_MemWrite(cur.memWrite), .id_MemtoReg(cur.memtoReg), .id_Branch(cur.branch),
        .id_ALUSrc(cur.aluSrc), .id_ALUOp(cur.aluOp),
        .ex_valid(ex_valid), .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_RegDst(ex_RegDst), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
        .ex_MemWrite(ex_MemWrite), .ex_MemtoReg(ex_MemtoReg), .ex_Branch(ex_Branch),
        .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp), .stall(stall), .stall_cnt(stall_cnt)
    );

    // ---------------- second DUT, 2-bit counter, same stimulus ----------------
    logic              b_valid, b_RegDst, b_RegWrite, b_MemRead, b_MemWrite;
    logic              b_MemtoReg, b_Branch, b_ALUSrc, b_stall;
    logic [1:0]        b_ALUOp;
    logic [DATA_W-1:0] b_pc4, b_rs_data, b_rt_data, b_imm;
    logic [REG_AW-1:0] b_rs, b_rt, b_rd;
    logic [1:0]        b_cnt;

    id_ex_pipe_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(cur.valid),
        .id_pc4(cur.pc4), .id_rs_data(cur.rsData), .id_rt_data(cur.rtData), .id_imm(cur.imm),
        .id_rs(cur.rs), .id_rt(cur.rt), .id_rd(cur.rd),
        .id_RegDst(cur.regDst), .id_RegWrite(cur.regWrite), .id_MemRead(cur.memRead),
        .id_MemWrite(cur.memWrite), .id_MemtoReg(cur.memtoReg), .id_Branch(cur.branch),
        .id_ALUSrc(cur.aluSrc), .id_ALUOp(cur.aluOp),
        .ex_valid(b_valid), .ex_pc4(b_pc4), .ex_rs_data(b_rs_data), .ex_rt_data(b_rt_data),
        .ex_imm(b_imm), .ex_rs(b_rs), .ex_rt(b_rt), .ex_rd(b_rd),
        .ex_RegDst(b_RegDst), .ex_RegWrite(b_RegWrite), .ex_MemRead(b_MemRead),
        .ex_MemWrite(b_MemWrite), .ex_MemtoReg(b_MemtoReg), .ex_Branch(b_Branch),
        .ex_ALUSrc(b_ALUSrc), .ex_ALUOp(b_ALUOp), .stall(b_stall), .stall_cnt(b_cnt)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int total = 0;
    int bad = 0;
    logic checkEn = 1'b0;
    logic [DATA_W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // EX holds whatever instruction the front end last handed over, or nothing.
    logic mValid = 1'b0;
    ins_t mIns = '0;
    int   mStalls = 0;

    // Would the instruction now in ID read the value a load in EX has not produced yet?
    function automatic logic modelStall();
        logic readsRt;
        if (!cur.valid || !mValid || !mIns.memRead || mIns.rt == 0) return 1'b0;
        if (flush) return 1'b0;
        readsRt = !cur.aluSrc || cur.memWrite || cur.branch;
        return (mIns.rt == cur.rs) || (readsRt && mIns.rt == cur.rt);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mValid  = 1'b0;
            mIns    = '0;
            mStalls = 0;
            exp_q.delete();
        end else if (modelStall() || flush || !cur.valid) begin
            if (modelStall()) mStalls++;
            mValid = 1'b0;
            mIns   = '0;
        end else begin
            mValid = 1'b1;
            mIns   = cur;
            exp_q.push_back(cur.pc4);
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (checkEn) begin
            chk("stall", stall, modelStall());
            chk("stall2", b_stall, modelStall());
            chk("ex_valid", ex_valid, mValid);
            chk("RegWrite", ex_RegWrite, mIns.regWrite);
            chk("MemRead", ex_MemRead, mIns.memRead);
            chk("MemWrite", ex_MemWrite, mIns.memWrite);
            chk("Branch", ex_Branch, mIns.branch);
            chk("ALUSrc", ex_ALUSrc, mIns.aluSrc);
            chk("ALUOp", ex_ALUOp, mIns.aluOp);
            if (!mValid || mIns.regWrite) begin
                chk("RegDst", ex_RegDst, mIns.regDst);
                chk("MemtoReg", ex_MemtoReg, mIns.memtoReg);
            end
            chk("cnt16", stall_cnt, (mStalls > 65535) ? 65535 : mStalls);
            chk("cnt2", b_cnt, (mStalls > 3) ? 3 : mStalls);
            if (mValid) begin
                if (exp_q.size() == 0) chk("exp_q_empty", 1, 0);
                else chk("pc4_order", ex_pc4, exp_q.pop_front());
                chk("rs_data", ex_rs_data, mIns.rsData);
                chk("rt_data", ex_rt_data, mIns.rtData);
                chk("imm", ex_imm, mIns.imm);
                chk("rs", ex_rs, mIns.rs);
                chk("rt", ex_rt, mIns.rt);
                chk("rd", ex_rd, mIns.rd);
            end
        end
    end

    // ---------------- instruction builders ----------------
    logic [DATA_W-1:0] pcCtr = 32'h0000_1004;

    function automatic ins_t base(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        ins_t i;
        i = '0;
        i.valid  = 1'b1;
        i.pc4    = pcCtr;
        pcCtr    = pcCtr + 4;
        i.rsData = $urandom;
        i.rtData = $urandom;
        i.imm    = $urandom;
        i.rs = rs; i.rt = rt; i.rd = rd;
        return i;
    endfunction

    function automatic ins_t rType(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        ins_t i = base(rs, rt, rd);
        i.regDst = 1'b1; i.regWrite = 1'b1; i.aluOp = 2'b10;
        return i;
    endfunction

    function automatic ins_t lw(input logic [4:0] rs, input logic [4:0] rt);
        ins_t i = base(rs, rt, 5'($urandom_range(0, 31)));
        i.regWrite = 1'b1; i.memRead = 1'b1; i.memtoReg = 1'b1; i.aluSrc = 1'b1;
        return i;
    endfunction

    function automatic ins_t sw(input logic [4:0] rs, input logic [4:0] rt);
        ins_t i = base(rs, rt, 5'($urandom_range(0, 31)));
        i.memWrite = 1'b1; i.aluSrc = 1'b1; i.regDst = 1'bx; i.memtoReg = 1'bx;
        return i;
    endfunction

    function automatic ins_t beq(input logic [4:0] rs, input logic [4:0] rt);
        ins_t i = base(rs, rt, 5'($urandom_range(0, 31)));
        i.branch = 1'b1; i.aluOp = 2'b01; i.regDst = 1'bx; i.memtoReg = 1'bx;
        return i;
    endfunction

    // ---------------- driver ----------------
    // Present one instruction, re-presenting it while the interlock holds it.
    task automatic send(input ins_t ins, input logic fl, output logic firstStall, output int edges);
        logic st;
        edges = 0;
        firstStall = 1'b0;
        cur = ins;
        flush = fl;
        do begin
            @(negedge clk);
            st = stall;
            if (edges == 0) firstStall = st;
            @(posedge clk);
            #1;
            edges++;
        end while (st && edges < 4);
        if (st) chk("stall_release", 1, 0);
        cur.valid = 1'b0;
        flush = 1'b0;
    endtask

    ins_t idle;
    logic fs;
    int   ne;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. reset with random ID contents
        for (int i = 0; i < 2; i++) begin
            cur = base(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            cur.valid = 1'($urandom_range(0, 1));
            cur.memRead = 1'($urandom_range(0, 1));
            cur.regWrite = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            checkEn = 1'b1;
        end
        @(negedge clk);
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_stall", stall, 0);
        chk("rst_cnt", stall_cnt, 0);
        chk("rst_regwrite", ex_RegWrite, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle = '0;
        cur = idle;
        @(posedge clk);
        #1;

        // 2. independent add then sub
        send(rType(5'd1, 5'd2, 5'd3), 1'b0, fs, ne);
        chk("add_stall", fs, 0);
        chk("add_regdst", ex_RegDst, 1);
        chk("add_aluop", ex_ALUOp, 2'b10);
        chk("add_valid", ex_valid, 1);
        send(rType(5'd4, 5'd5, 5'd6), 1'b0, fs, ne);
        chk("sub_stall", fs, 0);
        chk("sub_rd", ex_rd, 6);

        // 3. lw $8 then add using $8: one stall, bubble, then add
        send(lw(5'd1, 5'd8), 1'b0, fs, ne);
        send(rType(5'd8, 5'd2, 5'd10), 1'b0, fs, ne);
        chk("lu_stall", fs, 1);
        chk("lu_edges", ne, 2);
        chk("lu_add_valid", ex_valid, 1);
        chk("lu_add_rs", ex_rs, 8);
        chk("lu_cnt", stall_cnt, 1);

        // 4. boundary cases of the hazard rule
        send(lw(5'd1, 5'd0), 1'b0, fs, ne);
        send(rType(5'd0, 5'd3, 5'd4), 1'b0, fs, ne);
        chk("r0_nostall", fs, 0);
        send(lw(5'd1, 5'd9), 1'b0, fs, ne);
        send(lw(5'd2, 5'd9), 1'b0, fs, ne);
        chk("lw_rt_nostall", fs, 0);
        send(lw(5'd1, 5'd9), 1'b0, fs, ne);
        send(sw(5'd2, 5'd9), 1'b0, fs, ne);
        chk("sw_rt_stall", fs, 1);
        send(lw(5'd1, 5'd9), 1'b0, fs, ne);
        send(beq(5'd3, 5'd9), 1'b0, fs, ne);
        chk("beq_rt_stall", fs, 1);
        chk("cnt_after4", stall_cnt, 3);

        // 5. hazard squashed by flush in the same cycle
        send(lw(5'd1, 5'd8), 1'b0, fs, ne);
        send(rType(5'd8, 5'd2, 5'd10), 1'b1, fs, ne);
        chk("flush_nostall", fs, 0);
        chk("flush_bubble", ex_valid, 0);
        chk("flush_cnt", stall_cnt, 3);

        // 6. saturation of the narrow counter, then reset mid-stall
        for (int k = 0; k < 5; k++) begin
            send(lw(5'd1, 5'd9), 1'b0, fs, ne);
            send(rType(5'd2, 5'd9, 5'd11), 1'b0, fs, ne);
        end
        chk("sat_cnt16", stall_cnt, 8);
        chk("sat_cnt2", b_cnt, 3);
        send(lw(5'd1, 5'd9), 1'b0, fs, ne);
        cur = rType(5'd9, 5'd3, 5'd12);
        @(negedge clk);
        chk("mid_stall", stall, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", ex_valid, 0);
        @(negedge clk);
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_cnt16", stall_cnt, 0);
        chk("mid_rst_cnt2", b_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cur = idle;

        // drain and confirm every accepted instruction reached EX
        repeat (3) @(posedge clk);
        #1;
        chk("exp_q_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
